// File: rtl/css_mcu0_el2_dbg_abscmd_ctl_if.sv
// Abstract-command bus bundle: DMI request/response plus core dbg_cmd port.
// Modports: slave = sequencer side, master = DMI block + core side.
interface css_mcu0_el2_dbg_abscmd_ctl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        core_halted;
  logic        dbg_cmd_valid;
  logic        dbg_cmd_write;
  logic [1:0]  dbg_cmd_type;
  logic [31:0] dbg_cmd_addr;
  logic [31:0] dbg_cmd_wrdata;
  logic        dec_dbg_cmd_done;
  logic        dec_dbg_cmd_fail;
  logic [31:0] dec_dbg_rddata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;

  modport slave (
    input  req_valid, req_write, req_type,
    input  req_addr, req_wdata, core_halted,
    input  dec_dbg_cmd_done, dec_dbg_cmd_fail,
    input  dec_dbg_rddata, rsp_ready,
    output req_ready, dbg_cmd_valid,
    output dbg_cmd_write, dbg_cmd_type,
    output dbg_cmd_addr, dbg_cmd_wrdata,
    output rsp_valid, rsp_err, rsp_rdata, busy
  );

  modport master (
    output req_valid, req_write, req_type,
    output req_addr, req_wdata, core_halted,
    output dec_dbg_cmd_done, dec_dbg_cmd_fail,
    output dec_dbg_rddata, rsp_ready,
    input  req_ready, dbg_cmd_valid,
    input  dbg_cmd_write, dbg_cmd_type,
    input  dbg_cmd_addr, dbg_cmd_wrdata,
    input  rsp_valid, rsp_err, rsp_rdata, busy
  );
endinterface

// File: rtl/css_mcu0_el2_dbg_abscmd_ctl.sv
// Abstract GPR/CSR command sequencer: accept, issue to core, wait, respond.
// Ports: clk, rst_l (sync active-low), bus (slave modport of the _if).
// Macro CSS_MCU0_DBG_CMD_TIMEOUT_EN adds the WAIT timeout (err 7) path.
module css_mcu0_el2_dbg_abscmd_ctl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_l,
  css_mcu0_el2_dbg_abscmd_ctl_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_tmo_range
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_ready;
  logic        cmd_valid;
  logic        rsp_valid;

`ifdef CSS_MCU0_DBG_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      write_q <= 1'b0;
      type_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 3'd0;
      rdata_q <= '0;
`ifdef CSS_MCU0_DBG_CMD_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      write_q <= write_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef CSS_MCU0_DBG_CMD_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
`ifdef CSS_MCU0_DBG_CMD_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    req_ready = 1'b0;
    cmd_valid = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          write_d = bus.req_write;
          // bit 1 only ever marks a rejected type, so
          // the core-facing type stays 0/1
          type_d  = {1'b0, bus.req_type[0]};
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = 3'd0;
          if (bus.req_type[1]) begin
            err_d   = 3'd2;
            state_d = RESP;
          end else if (!bus.core_halted) begin
            err_d   = 3'd4;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        state_d   = WAIT;
`ifdef CSS_MCU0_DBG_CMD_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      WAIT: begin
        // done has priority over a same-cycle timeout
        if (bus.dec_dbg_cmd_done) begin
          err_d   = bus.dec_dbg_cmd_fail ? 3'd3 : 3'd0;
          rdata_d = (!bus.dec_dbg_cmd_fail && !write_q)
                  ? bus.dec_dbg_rddata : '0;
          state_d = RESP;
        end
`ifdef CSS_MCU0_DBG_CMD_TIMEOUT_EN
        else if (cnt_q >= TMAX) begin
          err_d   = 3'd7;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready      = req_ready;
  assign bus.dbg_cmd_valid  = cmd_valid;
  assign bus.dbg_cmd_write  = write_q;
  assign bus.dbg_cmd_type   = type_q;
  assign bus.dbg_cmd_addr   = addr_q;
  assign bus.dbg_cmd_wrdata = wdata_q;
  assign bus.rsp_valid      = rsp_valid;
  assign bus.rsp_err        = err_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_css_mcu0_el2_dbg_abscmd_ctl.sv
// Directed bench for the abstract-command sequencer.
// Expected responses are queued at request time, popped at rsp_valid.
module tb_css_mcu0_el2_dbg_abscmd_ctl;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  css_mcu0_el2_dbg_abscmd_ctl_if bus ();

  css_mcu0_el2_dbg_abscmd_ctl #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  typedef struct packed {
    logic [2:0]  err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic w, input logic [1:0] t,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input logic h);
    bus.req_valid   = 1'b1;
    bus.req_write   = w;
    bus.req_type    = t;
    bus.req_addr    = a;
    bus.req_wdata   = d;
    bus.core_halted = h;
  endtask

  task automatic take_rsp(input string tag);
    rsp_t e;
    chk({tag, "_rspv"}, bus.rsp_valid, 1'b1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err"}, bus.rsp_err, e.err);
      chk({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_rdy_after"}, bus.req_ready, 1'b1);
    chk({tag, "_rspv_after"}, bus.rsp_valid, 1'b0);
  endtask

  initial begin
    bus.req_valid        = 1'b0;
    bus.req_write        = 1'b0;
    bus.req_type         = 2'd0;
    bus.req_addr         = '0;
    bus.req_wdata        = '0;
    bus.core_halted      = 1'b0;
    bus.dec_dbg_cmd_done = 1'b0;
    bus.dec_dbg_cmd_fail = 1'b0;
    bus.dec_dbg_rddata   = '0;
    bus.rsp_ready        = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cmdv", bus.dbg_cmd_valid, 1'b0);
    chk("rst_cmd", {bus.dbg_cmd_write, bus.dbg_cmd_type,
                    bus.dbg_cmd_addr}, 35'd0);
    chk("rst_wr", bus.dbg_cmd_wrdata, 32'd0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err,
                    bus.rsp_rdata}, 36'd0);
    rst_l = 1'b1;
    tick();

    // GPR read, done 3 cycles after issue
    drive_req(1'b0, 2'd0, 32'd5, 32'd0, 1'b1);
    sb.push_back({3'd0, 32'hDEADBEEF});
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h1F;
    chk("gr_cmdv", bus.dbg_cmd_valid, 1'b1);
    chk("gr_addr", bus.dbg_cmd_addr, 32'd5);
    chk("gr_wt", {bus.dbg_cmd_write, bus.dbg_cmd_type}, 3'd0);
    chk("gr_ready", bus.req_ready, 1'b0);
    chk("gr_busy", bus.busy, 1'b1);
    tick();
    chk("gr_cmdv_1cyc", bus.dbg_cmd_valid, 1'b0);
    tick();
    tick();
    bus.dec_dbg_cmd_done = 1'b1;
    bus.dec_dbg_rddata   = 32'hDEADBEEF;
    chk("gr_no_rsp_yet", bus.rsp_valid, 1'b0);
    tick();
    bus.dec_dbg_cmd_done = 1'b0;
    chk("gr_addr_resp", bus.dbg_cmd_addr, 32'd5);
    take_rsp("gr");

    // CSR write, response held while rsp_ready low
    drive_req(1'b1, 2'd1, 32'h7C4, 32'h1, 1'b1);
    sb.push_back({3'd0, 32'h0});
    tick();
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'hFFFF;
    chk("cw_cmdv", bus.dbg_cmd_valid, 1'b1);
    chk("cw_addr", bus.dbg_cmd_addr, 32'h7C4);
    chk("cw_wt", {bus.dbg_cmd_write, bus.dbg_cmd_type}, 3'b101);
    chk("cw_wdata", bus.dbg_cmd_wrdata, 32'h1);
    tick();
    bus.dec_dbg_cmd_done = 1'b1;
    bus.dec_dbg_rddata   = 32'h5555;
    tick();
    bus.dec_dbg_cmd_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("cw_hold_v", bus.rsp_valid, 1'b1);
      chk("cw_hold_r", {bus.rsp_err, bus.rsp_rdata}, 35'd0);
      chk("cw_hold_wd", bus.dbg_cmd_wrdata, 32'h1);
      tick();
    end
    take_rsp("cw");

    // unsupported type 2
    drive_req(1'b0, 2'd2, 32'd3, 32'd0, 1'b1);
    sb.push_back({3'd2, 32'h0});
    tick();
    bus.req_valid = 1'b0;
    chk("t2_cmdv", bus.dbg_cmd_valid, 1'b0);
    take_rsp("t2");

    // not halted
    drive_req(1'b0, 2'd0, 32'd3, 32'd0, 1'b0);
    sb.push_back({3'd4, 32'h0});
    tick();
    bus.req_valid = 1'b0;
    bus.core_halted = 1'b1;
    chk("nh_cmdv", bus.dbg_cmd_valid, 1'b0);
    take_rsp("nh");

    // CSR read with fault
    drive_req(1'b0, 2'd1, 32'h300, 32'd0, 1'b1);
    sb.push_back({3'd3, 32'h0});
    tick();
    bus.req_valid = 1'b0;
    chk("cf_cmdv", bus.dbg_cmd_valid, 1'b1);
    tick();
    bus.dec_dbg_cmd_done = 1'b1;
    bus.dec_dbg_cmd_fail = 1'b1;
    bus.dec_dbg_rddata   = 32'h1234;
    tick();
    bus.dec_dbg_cmd_done = 1'b0;
    bus.dec_dbg_cmd_fail = 1'b0;
    take_rsp("cf");

    // no done: timeout or indefinite wait
    drive_req(1'b0, 2'd0, 32'd9, 32'd0, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    tick();
`ifdef CSS_MCU0_DBG_CMD_TIMEOUT_EN
    sb.push_back({3'd7, 32'h0});
    for (int i = 0; i < int'(TMO); i++) tick();
    chk("to_early", bus.rsp_valid, 1'b0);
    tick();
    chk("to_at", bus.rsp_valid, 1'b1);
    bus.dec_dbg_cmd_done = 1'b1;
    bus.dec_dbg_rddata   = 32'h99;
    tick();
    bus.dec_dbg_cmd_done = 1'b0;
    take_rsp("to");
`else
    sb.push_back({3'd0, 32'h77});
    for (int i = 0; i < 1000; i++) tick();
    chk("nt_wait_v", bus.rsp_valid, 1'b0);
    chk("nt_wait_b", bus.busy, 1'b1);
    bus.dec_dbg_cmd_done = 1'b1;
    bus.dec_dbg_rddata   = 32'h77;
    tick();
    bus.dec_dbg_cmd_done = 1'b0;
    take_rsp("nt");
`endif

    // reset during WAIT, then late done
    drive_req(1'b0, 2'd0, 32'd6, 32'd0, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    chk("rw_cmdv", bus.dbg_cmd_valid, 1'b0);
    chk("rw_ready", bus.req_ready, 1'b1);
    bus.dec_dbg_cmd_done = 1'b1;
    bus.dec_dbg_rddata   = 32'hABC;
    tick();
    bus.dec_dbg_cmd_done = 1'b0;
    chk("rw_no_rsp", bus.rsp_valid, 1'b0);
    chk("rw_idle", {bus.busy, bus.req_ready}, 2'b01);

    // next request, minimum latency: accept N -> rsp N+3
    drive_req(1'b0, 2'd0, 32'd7, 32'd0, 1'b1);
    sb.push_back({3'd0, 32'hCAFEF00D});
    tick();
    bus.req_valid = 1'b0;
    chk("mn_cmdv", bus.dbg_cmd_valid, 1'b1);
    tick();
    bus.dec_dbg_cmd_done = 1'b1;
    bus.dec_dbg_rddata   = 32'hCAFEF00D;
    tick();
    bus.dec_dbg_cmd_done = 1'b0;
    take_rsp("mn");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/css_mcu0_el2_dbg_abscmd_ctl.md
# css_mcu0_el2_dbg_abscmd_ctl

Debug-module-side sequencer for abstract register commands into the halted core. It accepts one GPR/CSR access request from the DMI register block and rejects unsupported or illegal requests locally. It drives the core's `dbg_cmd_*` injection interface for exactly one cycle per legal request, waits for the core's done/fail completion, then returns read data and a cmderr-coded status through a valid/ready response.

## Interface
- `TIMEOUT_CYCLES`, default 255: WAIT cycles without done before a timeout error; legal range 1..65535.

- `clk`  in  1  core clock
- `rst_l`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  abstract command request
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_write`  in  1  1 = register write, 0 = read
- `req_type`  in  2  0 = GPR, 1 = CSR, 2/3 = unsupported here
- `req_addr`  in  32  GPR index in [4:0], CSR number in [11:0]
- `req_wdata`  in  32  write data
- `core_halted`  in  1  core is in debug halt
- `dbg_cmd_valid`  out  1  command to the decode stage
- `dbg_cmd_write`  out  1  write command
- `dbg_cmd_type`  out  2  0 = GPR, 1 = CSR; never 2
- `dbg_cmd_addr`  out  32  register address
- `dbg_cmd_wrdata`  out  32  write data, sourced to rs1 by the core
- `dec_dbg_cmd_done`  in  1  core completed the command
- `dec_dbg_cmd_fail`  in  1  qualifies done: command faulted
- `dec_dbg_rddata`  in  32  read result, valid with done
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumed
- `rsp_err`  out  3  0 none, 2 notsupported, 3 exception, 4 haltresume, 7 other (timeout)
- `rsp_rdata`  out  32  read data; 0 for writes and errors
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Encoding is free.
- IDLE
  - `req_ready = 1`.
  - On accept, capture write, type, addr and wdata into the command registers.
  - `req_type[1] = 1` -> RESP, err 2.
  - Else if `!core_halted` -> RESP, err 4.
  - Else -> ISSUE.
- ISSUE
  - `dbg_cmd_valid = 1` for exactly this cycle.
  - Always -> WAIT; clear the timeout counter.
- WAIT
  - On `dec_dbg_cmd_done`: err 3 if fail, else err 0.
  - Capture `dec_dbg_rddata` only for successful reads; otherwise capture 0.
  - Done -> RESP.
  - The timeout counter increments each WAIT cycle. When it reaches `TIMEOUT_CYCLES` without done -> RESP, err 7, rdata 0.
- RESP
  - `rsp_valid = 1`.
  - `rsp_err` and `rsp_rdata` are held stable until `rsp_valid & rsp_ready`, then -> IDLE.
- `dbg_cmd_write/type/addr/wrdata` are registered and stable from ISSUE through the end of RESP; they do not change until the next accept.
- `req_ready = 0` in every state except IDLE; no request queueing.
- `dec_dbg_cmd_done` outside WAIT is ignored. This covers late done after a timeout and done coincident with ISSUE.
- done and timeout in the same cycle: done wins.
- `core_halted` is sampled only at accept. Loss of halt during WAIT is not checked; completion or timeout resolves it.
- Reset mid-operation:
  - Next state is IDLE and `dbg_cmd_valid` drops.
  - Any pending response is discarded.
  - A following done is ignored.

## Timing
- Reset values:
  - state IDLE, so `req_ready = 1` and `busy = 0`.
  - `dbg_cmd_valid`, `dbg_cmd_write`, `dbg_cmd_type`, `dbg_cmd_addr`, `dbg_cmd_wrdata`, `rsp_valid`, `rsp_err`, `rsp_rdata` all 0; timeout counter 0.
- Accept at cycle N:
  - Rejected request: `rsp_valid` at N+1.
  - Legal request: `dbg_cmd_valid` at N+1, WAIT from N+2.
- done at WAIT cycle M -> `rsp_valid` at M+1. Minimum legal-command latency is accept to `rsp_valid` = 3 cycles.
- Timeout: `rsp_valid` at `TIMEOUT_CYCLES + 1` cycles after WAIT entry.
- Response handshake completing at cycle R -> `req_ready` at R+1. Back-to-back requests are separated by at least one IDLE cycle.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits, saturating compare, and never wraps.

## Configuration
- `CSS_MCU0_DBG_CMD_TIMEOUT_EN`
  - Defined: timeout counter and err 7 path present, as above.
  - Undefined: no counter logic; WAIT exits only on done; `rsp_err` never 7; `TIMEOUT_CYCLES` is unused.

## Test plan
- GPR read: halted, type 0, write 0, addr 5; done 3 cycles after issue with rddata 0xDEADBEEF -> single-cycle `dbg_cmd_valid` with addr 5; `rsp_valid`, err 0, rdata 0xDEADBEEF.
- CSR write: addr 0x7C4, wdata 0x1, done with no fail -> wrdata 0x1 held through RESP; err 0, rdata 0; `rsp_ready` held low 5 cycles keeps the response stable.
- Type 2 request, and separately an un-halted type 0 request -> no `dbg_cmd_valid`; `rsp_valid` at N+1 with err 2 and err 4 respectively.
- CSR read with done + fail, rddata 0x1234 -> err 3, rdata 0.
- Macro defined, `TIMEOUT_CYCLES` = 16, no done -> err 7 with `rsp_valid` 17 cycles after WAIT entry; a done injected during RESP is ignored. Macro undefined -> still waiting after 1000 cycles.
- `rst_l` low for 1 cycle during WAIT, then done -> IDLE, `req_ready = 1`, no `rsp_valid`; the next request completes normally.
